imem_loader: RTL and testbench

- Writer-side counterpart of the core's combinational instruction memory.
- Receives a program image as a byte stream (from the UART receiver or a debug bridge) and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction RAM write port at incrementing word addresses.
- Holds the pipelined core in reset until a complete, checksum-verified image has been loaded.

---
 rtl/imem_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Assembles a length-prefixed, XOR-checksummed byte stream into 32-bit words and writes them to instruction RAM.
// Write issues one cycle after the 4th byte of a word; rx_ready is low outside loading states and while start is high.
module imem_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [7:0]            chk_q, chk_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;

    logic        loading;
    logic        accept;
    logic [15:0] len_n;

    assign loading = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                     (state_q == S_DATA) || (state_q == S_CHK);
    assign len_n   = {rx_data, count_q[7:0]};

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        chk_d        = chk_q;
        tmo_d        = tmo_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        word_count_d = word_count_q;
        rx_ready     = loading && !start;
        accept       = rx_valid && rx_ready;

        if (start) begin
            state_d      = S_LEN0;
            count_d      = '0;
            word_idx_d   = '0;
            byte_idx_d   = '0;
            chk_d        = '0;
            word_count_d = '0;
            tmo_d        = '0;
        end else begin
            if (loading) begin
                tmo_d = accept ? '0 : tmo_q + TW'(1);
            end
            case (state_q)
                S_LEN0: begin
                    if (accept) begin
                        count_d[7:0] = rx_data;
                        state_d      = S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (accept) begin
                        count_d    = len_n;
                        byte_idx_d = '0;
                        word_idx_d = '0;
                        if ((len_n == 16'd0) || (32'(len_n) > DEPTH)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        // little-endian: byte 0 ends up in bits [7:0] after four shifts
                        word_d     = {rx_data, word_q[DATA_WIDTH-1:8]};
                        chk_d      = chk_q ^ rx_data;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            wr_en_d      = 1'b1;
                            wr_addr_d    = word_idx_q[ADDR_WIDTH-1:0];
                            wr_data_d    = word_d;
                            word_idx_d   = word_idx_q + (ADDR_WIDTH+1)'(1);
                            word_count_d = word_count_q + (ADDR_WIDTH+1)'(1);
                            if (32'(word_idx_q) + 32'd1 == 32'(count_q)) begin
                                state_d = S_CHK;
                            end
                        end
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
                    end
                end
                default: ;
            endcase
            // an accepted byte on the final count cycle cancels the timeout
            if (TIMEOUT_CYCLES != 0 && loading && !accept &&
                tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_ERR;
                tmo_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            chk_q        <= '0;
            tmo_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            chk_q        <= chk_d;
            tmo_q        <= tmo_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            word_count_q <= word_count_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_count = word_count_q;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign core_hold  = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random image loads checked against a stream-level reference model.
module tb_imem_loader;
    localparam int AW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready, wr_en, core_hold, done, error;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW:0]   word_count;

    imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .word_count(word_count), .core_hold(core_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]    stream[$];
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    logic          exp_done, exp_err;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: length-prefixed little-endian words, checksum is XOR of data bytes only.
    task automatic build_expect();
        int n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = int'({stream[1], stream[0]});
        if (n == 0 || n > (1 << AW)) begin
            exp_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                w = w | (32'(stream[2 + 4*i + k]) << (8*k));
                x = x ^ stream[2 + 4*i + k];
            end
            exp_addr.push_back(AW'(i));
            exp_data.push_back(w);
        end
        if (stream[2 + 4*n] == x) exp_done = 1'b1;
        else                      exp_err  = 1'b1;
    endtask

    task automatic make_random(input int n, input bit corrupt);
        logic [7:0] x, b;
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        x = 8'h00;
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
            x = x ^ b;
        end
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        stream.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        while (rx_ready !== 1'b1 && t < 40) begin
            t++;
            @(negedge clk);
        end
        if (rx_ready !== 1'b1) check("rx_ready_wait", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_stream(input int max_gap);
        foreach (stream[i]) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            send_byte(stream[i]);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        got_addr.delete();
        got_data.delete();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_result(input string tag);
        @(negedge clk);
        check({tag, "/done"}, 64'(done), 64'(exp_done));
        check({tag, "/error"}, 64'(error), 64'(exp_err));
        check({tag, "/core_hold"}, 64'(core_hold), 64'(!exp_done));
        check({tag, "/word_count"}, 64'(word_count), 64'(exp_addr.size()));
        check({tag, "/writes"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check({tag, "/wr_addr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
            check({tag, "/wr_data"}, 64'(got_data[i]), 64'(exp_data[i]));
        end
    endtask

    task automatic hold_valid(input string tag, input int cycles);
        int nw;
        nw = got_addr.size();
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        repeat (cycles) begin
            @(negedge clk);
            check({tag, "/rx_ready"}, 64'(rx_ready), 64'd0);
        end
        check({tag, "/done"}, 64'(done), 64'(exp_done));
        check({tag, "/error"}, 64'(error), 64'(exp_err));
        check({tag, "/core_hold"}, 64'(core_hold), 64'(!exp_done));
        check({tag, "/no_write"}, 64'(got_addr.size()), 64'(nw));
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst/rx_ready", 64'(rx_ready), 64'd0);
        check("rst/wr_en", 64'(wr_en), 64'd0);
        check("rst/word_count", 64'(word_count), 64'd0);
        check("rst/core_hold", 64'(core_hold), 64'd1);
        check("rst/done", 64'(done), 64'd0);
        check("rst/error", 64'(error), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        hold_valid("idle_hold", 4);

        // Two-word directed image
        stream = '{8'h02, 8'h00, 8'h03, 8'h25, 8'h05, 8'h00, 8'h83, 8'hA5, 8'h45, 8'h00, 8'h40};
        build_expect();
        pulse_start();
        send_stream(0);
        check_result("basic");
        if (got_data.size() == 2) begin
            check("basic/word0", 64'(got_data[0]), 64'h00052503);
            check("basic/word1", 64'(got_data[1]), 64'h0045A583);
        end
        hold_valid("done_hold", 5);

        stream[10] = 8'h41;
        build_expect();
        pulse_start();
        send_stream(0);
        check_result("bad_chk");
        hold_valid("err_hold", 5);

        stream = '{8'h00, 8'h00};
        build_expect();
        pulse_start();
        send_stream(0);
        check_result("len_zero");

        stream = '{8'h01, 8'h01};
        build_expect();
        pulse_start();
        send_stream(0);
        check_result("len_257");

        // Timeout: three data bytes then silence
        make_random(1, 1'b0);
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(stream[i]);
        repeat (16) @(negedge clk);
        check("tmo/not_yet", 64'(error), 64'd0);
        @(negedge clk);
        check("tmo/error", 64'(error), 64'd1);
        check("tmo/core_hold", 64'(core_hold), 64'd1);
        check("tmo/no_write", 64'(got_addr.size()), 64'd0);

        // Byte arriving on the last idle cycle beats the timeout
        make_random(1, 1'b0);
        build_expect();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(stream[i]);
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        send_byte(stream[5]);
        send_byte(stream[6]);
        check_result("tmo_edge");

        // Restart mid-DATA with a byte on the wire
        make_random(2, 1'b0);
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(stream[i]);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        @(negedge clk);
        check("restart/rx_ready", 64'(rx_ready), 64'd0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        got_addr.delete();
        got_data.delete();
        make_random(3, 1'b0);
        build_expect();
        send_stream(2);
        check_result("restart");

        for (int r = 0; r < 8; r++) begin
            make_random($urandom_range(1, 12), ($urandom_range(0, 2) == 0));
            build_expect();
            pulse_start();
            send_stream(5);
            check_result("random");
        end

        make_random(256, 1'b0);
        build_expect();
        pulse_start();
        send_stream(0);
        check_result("full_depth");

        // Reset mid-word: partial word must never be written
        make_random(2, 1'b0);
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(stream[i]);
        rx_valid = 1'b1;
        rx_data  = stream[5];
        rst_n    = 1'b0;
        @(negedge clk);
        check("rst_mid/core_hold", 64'(core_hold), 64'd1);
        check("rst_mid/wr_en", 64'(wr_en), 64'd0);
        check("rst_mid/rx_ready", 64'(rx_ready), 64'd0);
        check("rst_mid/word_count", 64'(word_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        hold_valid("rst_idle", 5);
        check("rst_mid/no_write", 64'(got_addr.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
